// File: rtl/display_pkg.sv
// Shared types and 7-segment constants for the product display path.
// Segment vectors are active-low in gfedcba order.
package display_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_BLANCO = 7'h7F;
    localparam logic [6:0] SEG_MENOS  = 7'h3F;

    // BCD digit to active-low gfedcba pattern; non-decimal codes blank the digit.
    function automatic logic [6:0] bcd_a_7seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANCO;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/conversor_bin_bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, ANCHO steps per value.
// Accepts a start only in REPOSO; listo pulses on entry to FIN, when ocupado drops.
module conversor_bin_bcd
    import display_pkg::*;
#(
    parameter int unsigned ANCHO = 16,
    parameter int unsigned N_BCD = 5
) (
    input  logic                 reloj,
    input  logic                 reset,
    input  logic                 i_inicio,
    input  logic [ANCHO-1:0]     i_mag,
    input  logic                 i_neg,
    output logic                 o_ocupado,
    output logic                 o_listo,
    output logic [4*N_BCD-1:0]   o_bcd,
    output logic                 o_neg
);

    localparam int unsigned BCD_W = 4 * N_BCD;
    localparam int unsigned CNT_W = $clog2(ANCHO + 1);

    estado_t            r_estado, w_estado;
    logic [ANCHO-1:0]   r_bin, w_bin;
    logic [BCD_W-1:0]   r_bcd, w_bcd, w_ajuste;
    logic [CNT_W-1:0]   r_cuenta, w_cuenta;
    logic               r_neg, w_neg;
    logic               r_ocupado, w_ocupado;
    logic               r_listo, w_listo;

    // State and datapath registers; reset aborts any conversion silently.
    always_ff @(posedge reloj) begin
        if (!reset) begin
            r_estado  <= REPOSO;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cuenta  <= '0;
            r_neg     <= 1'b0;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            r_estado  <= w_estado;
            r_bin     <= w_bin;
            r_bcd     <= w_bcd;
            r_cuenta  <= w_cuenta;
            r_neg     <= w_neg;
            r_ocupado <= w_ocupado;
            r_listo   <= w_listo;
        end
    end

    always_comb begin
        w_estado  = r_estado;
        w_bin     = r_bin;
        w_bcd     = r_bcd;
        w_cuenta  = r_cuenta;
        w_neg     = r_neg;
        w_ocupado = r_ocupado;
        w_listo   = 1'b0;
        w_ajuste  = r_bcd;

        // Add 3 to every nibble >= 5 so the following shift carries correctly.
        for (int i = 0; i < int'(N_BCD); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_ajuste[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end

        case (r_estado)
            REPOSO: begin
                if (i_inicio) begin
                    w_estado  = DESPLAZA;
                    w_bin     = i_mag;
                    w_bcd     = '0;
                    w_cuenta  = '0;
                    w_neg     = i_neg;
                    w_ocupado = 1'b1;
                end
            end
            DESPLAZA: begin
                w_bcd    = {w_ajuste[BCD_W-2:0], r_bin[ANCHO-1]};
                w_bin    = {r_bin[ANCHO-2:0], 1'b0};
                w_cuenta = r_cuenta + CNT_W'(1);
                if (r_cuenta == CNT_W'(ANCHO - 1)) begin
                    w_estado  = FIN;
                    w_ocupado = 1'b0;
                    w_listo   = 1'b1;
                end
            end
            FIN: begin
                w_estado = REPOSO;
            end
            default: begin
                w_estado = REPOSO;
            end
        endcase
    end

    assign o_ocupado = r_ocupado;
    assign o_listo   = r_listo;
    assign o_bcd     = r_bcd;
    assign o_neg     = r_neg;

endmodule

// File: rtl/display_producto.sv
// Captures a signed product, converts its magnitude to BCD and scans it onto an
// N-digit multiplexed 7-segment display. Define BLANQUEO_CEROS_EN to blank leading zeros.
module display_producto
    import display_pkg::*;
#(
    parameter int unsigned ANCHO        = 16,
    parameter int unsigned N_DIGITOS    = 6,
    parameter int unsigned DIV_REFRESCO = 100000
) (
    input  logic                    reloj,
    input  logic                    reset,
    input  logic signed [ANCHO-1:0] producto,
    input  logic                    cargar,
    output logic                    ocupado,
    output logic                    listo,
    output logic [2:0]              digito_sel,
    output logic [N_DIGITOS-1:0]    anodos,
    output logic [6:0]              segmentos
);

    localparam int unsigned N_BCD   = N_DIGITOS - 1;
    localparam int unsigned BCD_W   = 4 * N_BCD;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned PRESC_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;

    logic [ANCHO-1:0]     w_prod_u, w_mag;
    logic                 w_ocupado, w_listo, w_neg;
    logic [BCD_W-1:0]     w_bcd;
    logic [PRESC_W-1:0]   r_presc;
    logic [SEL_W-1:0]     r_digito_sel;
    logic [BCD_W-1:0]     r_buf_bcd;
    logic                 r_buf_neg;
    logic [N_DIGITOS-1:0] r_anodos;
    logic [6:0]           r_segmentos;
    logic [3:0]           w_nib;
    logic [6:0]           w_seg_c;

    // Magnitude as unsigned: the most negative value maps to 2^(ANCHO-1).
    assign w_prod_u = producto;
    assign w_mag    = w_prod_u[ANCHO-1] ? (~w_prod_u + ANCHO'(1)) : w_prod_u;

    conversor_bin_bcd #(
        .ANCHO (ANCHO),
        .N_BCD (N_BCD)
    ) u_conversor (
        .reloj     (reloj),
        .reset     (reset),
        .i_inicio  (cargar),
        .i_mag     (w_mag),
        .i_neg     (w_prod_u[ANCHO-1]),
        .o_ocupado (w_ocupado),
        .o_listo   (w_listo),
        .o_bcd     (w_bcd),
        .o_neg     (w_neg)
    );

    // Segment pattern for the digit currently selected by the scan counter.
    always_comb begin
        w_nib   = '0;
        w_seg_c = SEG_BLANCO;
        for (int i = 0; i < int'(N_BCD); i++) begin
            if (r_digito_sel == SEL_W'(i)) begin
                w_nib = r_buf_bcd[4*i +: 4];
            end
        end
        if (r_digito_sel == SEL_W'(N_DIGITOS - 1)) begin
            w_seg_c = r_buf_neg ? SEG_MENOS : SEG_BLANCO;
        end else begin
            w_seg_c = bcd_a_7seg(w_nib);
        end
`ifdef BLANQUEO_CEROS_EN
        begin : blanqueo
            logic w_ceros_arriba;
            w_ceros_arriba = 1'b1;
            for (int i = int'(N_BCD) - 1; i >= 1; i--) begin
                w_ceros_arriba = w_ceros_arriba & (r_buf_bcd[4*i +: 4] == 4'd0);
                if ((r_digito_sel == SEL_W'(i)) && w_ceros_arriba) begin
                    w_seg_c = SEG_BLANCO;
                end
            end
        end
`endif
    end

    // Prescaler, scan counter, display buffer and registered pin drivers.
    always_ff @(posedge reloj) begin
        if (!reset) begin
            r_presc      <= '0;
            r_digito_sel <= '0;
            r_buf_bcd    <= '0;
            r_buf_neg    <= 1'b0;
            r_anodos     <= '1;
            r_segmentos  <= SEG_BLANCO;
        end else begin
            if (r_presc == PRESC_W'(DIV_REFRESCO - 1)) begin
                r_presc <= '0;
                if (r_digito_sel == SEL_W'(N_DIGITOS - 1)) begin
                    r_digito_sel <= '0;
                end else begin
                    r_digito_sel <= r_digito_sel + SEL_W'(1);
                end
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
            if (w_listo) begin
                r_buf_bcd <= w_bcd;
                r_buf_neg <= w_neg;
            end
            r_anodos    <= ~(N_DIGITOS'(1) << r_digito_sel);
            r_segmentos <= w_seg_c;
        end
    end

    assign ocupado    = w_ocupado;
    assign listo      = w_listo;
    assign digito_sel = r_digito_sel;
    assign anodos     = r_anodos;
    assign segmentos  = r_segmentos;

endmodule

// File: tb/tb_display_producto.sv
// Directed bench for display_producto with a short refresh divider.
// Expected segment codes are hand-written active-low gfedcba patterns.
module tb_display_producto;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S6 = 7'h02, S7 = 7'h78, S8 = 7'h00;
    localparam logic [6:0] BLANCO = 7'h7F, MENOS = 7'h3F;
`ifdef BLANQUEO_CEROS_EN
    localparam logic [6:0] CERO_IZQ = 7'h7F;
`else
    localparam logic [6:0] CERO_IZQ = 7'h40;
`endif

    logic               reloj = 1'b0;
    logic               reset;
    logic signed [15:0] producto;
    logic               cargar;
    logic               ocupado, listo;
    logic [2:0]         digito_sel;
    logic [5:0]         anodos;
    logic [6:0]         segmentos;

    int n_pruebas = 0;
    int n_fallos  = 0;

    display_producto #(
        .ANCHO        (16),
        .N_DIGITOS    (6),
        .DIV_REFRESCO (4)
    ) dut (
        .reloj      (reloj),
        .reset      (reset),
        .producto   (producto),
        .cargar     (cargar),
        .ocupado    (ocupado),
        .listo      (listo),
        .digito_sel (digito_sel),
        .anodos     (anodos),
        .segmentos  (segmentos)
    );

    always #5 reloj = ~reloj;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_pruebas++;
        if (obs !== esp) begin
            n_fallos++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Waits for digit k's slot and checks the segments shown in it.
    task automatic chequear_digito(input string tag, input int k, input logic [6:0] esp);
        logic [5:0] obj;
        logic [6:0] seg;
        obj = ~(6'b1 << k);
        seg = 7'h55;
        for (int n = 0; n < 60; n++) begin
            @(negedge reloj);
            if (anodos == obj) begin
                seg = segmentos;
                break;
            end
        end
        chequear(tag, 32'(seg), 32'(esp));
    endtask

    // Issues one cargar and returns the cycle (relative to the request) of listo.
    task automatic cargar_valor(input logic signed [15:0] v, output int lat);
        @(negedge reloj);
        producto = v;
        cargar   = 1'b1;
        @(negedge reloj);
        cargar = 1'b0;
        lat    = 1;
        chequear("ocupado_tras_cargar", 32'(ocupado), 32'd1);
        while (!listo && lat < 40) begin
            @(negedge reloj);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n_listo;
        int c_listo;

        reset    = 1'b0;
        cargar   = 1'b0;
        producto = '0;

        // Reset state
        repeat (3) @(negedge reloj);
        chequear("reset_anodos", 32'(anodos), 32'h3F);
        chequear("reset_segmentos", 32'(segmentos), 32'h7F);
        chequear("reset_ocupado", 32'(ocupado), 32'd0);
        chequear("reset_listo", 32'(listo), 32'd0);
        reset = 1'b1;

        // Scan sequence: four cycles per slot, wrapping after digit 5
        for (int n = 1; n <= 25; n++) begin
            @(negedge reloj);
            if ((n % 4) == 1 || n == 4) begin
                chequear($sformatf("scan_n%0d", n), 32'(anodos),
                         32'(6'(~(6'b1 << (((n - 1) / 4) % 6)))));
            end
        end
        chequear_digito("rst_d0", 0, S0);
        chequear_digito("rst_d2", 2, CERO_IZQ);
        chequear_digito("rst_d5", 5, BLANCO);

        // 1234
        cargar_valor(16'sd1234, lat);
        chequear("lat_1234", 32'(lat), 32'd17);
        chequear("ocupado_en_listo", 32'(ocupado), 32'd0);
        @(negedge reloj);
        chequear("listo_un_ciclo", 32'(listo), 32'd0);
        chequear_digito("p1234_d0", 0, S4);
        chequear_digito("p1234_d1", 1, S3);
        chequear_digito("p1234_d2", 2, S2);
        chequear_digito("p1234_d3", 3, S1);
        chequear_digito("p1234_d4", 4, CERO_IZQ);
        chequear_digito("p1234_d5", 5, BLANCO);

        // Most negative value
        cargar_valor(-16'sd32768, lat);
        chequear("lat_min", 32'(lat), 32'd17);
        chequear_digito("min_d0", 0, S8);
        chequear_digito("min_d1", 1, S6);
        chequear_digito("min_d2", 2, S7);
        chequear_digito("min_d3", 3, S2);
        chequear_digito("min_d4", 4, S3);
        chequear_digito("min_d5", 5, MENOS);

        // Requests while busy (mid-conversion and in FIN) are dropped
        @(negedge reloj);
        producto = 16'sd1234;
        cargar   = 1'b1;
        n_listo  = 0;
        c_listo  = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge reloj);
            if (listo) begin
                n_listo++;
                c_listo = c;
            end
            cargar = (c == 5 || c == 17);
            if (cargar) producto = 16'sd999;
        end
        cargar = 1'b0;
        chequear("ocupado_n_listo", 32'(n_listo), 32'd1);
        chequear("ocupado_c_listo", 32'(c_listo), 32'd17);
        chequear("ocupado_final", 32'(ocupado), 32'd0);
        chequear_digito("ignora_d0", 0, S4);
        chequear_digito("ignora_d2", 2, S2);

        // Reset in the middle of a conversion
        @(negedge reloj);
        producto = 16'sd1234;
        cargar   = 1'b1;
        @(negedge reloj);
        cargar = 1'b0;
        repeat (7) @(negedge reloj);
        reset = 1'b0;
        @(negedge reloj);
        chequear("abort_ocupado", 32'(ocupado), 32'd0);
        chequear("abort_listo", 32'(listo), 32'd0);
        reset   = 1'b1;
        n_listo = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge reloj);
            if (listo) n_listo++;
        end
        chequear("abort_sin_listo", 32'(n_listo), 32'd0);
        chequear_digito("abort_d0", 0, S0);
        chequear_digito("abort_d3", 3, CERO_IZQ);
        chequear_digito("abort_d5", 5, BLANCO);

        // -7: leading zeros and sign
        cargar_valor(-16'sd7, lat);
        chequear("lat_m7", 32'(lat), 32'd17);
        chequear_digito("m7_d0", 0, S7);
        chequear_digito("m7_d1", 1, CERO_IZQ);
        chequear_digito("m7_d4", 4, CERO_IZQ);
        chequear_digito("m7_d5", 5, MENOS);

        // Zero: units shown, no sign
        cargar_valor(16'sd0, lat);
        chequear("lat_cero", 32'(lat), 32'd17);
        chequear_digito("cero_d0", 0, S0);
        chequear_digito("cero_d5", 5, BLANCO);

        $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
        $finish;
    end

endmodule
